jtag_host: RTL and testbench
============================

# jtag_host

JTAG initiator that drives the TCK/TMS/TDI pins of a JTAG target and samples its TDO. It takes bit-vector shift commands over a valid/ready command port and returns the captured TDO bits over a valid/ready response port. Used in the test harness and on companion dies to drive the chip's debug TAP from the other end of the link. It does not track the TAP state; the caller supplies every TMS bit.

## Interface
Parameters:
- `ClkDiv`, default 4: TCK half-period in `clk_i` cycles; must be ≥1.
- `MaxLen`, default 32: maximum bits per command; the `cmd_tms_i`, `cmd_tdi_i` and `rsp_tdo_o` widths.

Ports (one clock; reset is synchronous and active-high):
- `clk_i`  in  1  system clock
- `rst_i`  in  1  synchronous active-high reset
- `cmd_valid_i`  in  1  command valid
- `cmd_ready_o`  out  1  command accepted when high with valid
- `cmd_len_i`  in  $clog2(MaxLen)+1  number of bits to shift
- `cmd_tms_i`  in  MaxLen  TMS bit per TCK cycle, LSB first
- `cmd_tdi_i`  in  MaxLen  TDI bit per TCK cycle, LSB first
- `rsp_valid_o`  out  1  response valid
- `rsp_ready_i`  in  1  response consumed when high with valid
- `rsp_tdo_o`  out  MaxLen  captured TDO bits, LSB first; unused upper bits are 0
- `busy_o`  out  1  high in every state except IDLE
- `jtag_tck_o`  out  1  TCK
- `jtag_tms_o`  out  1  TMS
- `jtag_tdi_o`  out  1  TDI
- `jtag_tdo_i`  in  1  TDO from target
- `jtag_trst_no`  out  1  TRST, active low (present only with `JTAG_HOST_TRST_EN`)

## Operation
- FSM states:
  - IDLE: `cmd_ready_o`=1. On accept, latch the command and effective length `L`.
    - If `cmd_len_i` > MaxLen, `L`=MaxLen.
    - If `L`=0, go to RESP with `rsp_tdo_o`=0 and generate no TCK.
    - Otherwise go to LOW with bit index i=0.
  - LOW: `jtag_tck_o`=0, `jtag_tms_o`=tms[i], `jtag_tdi_o`=tdi[i]. Hold for ClkDiv cycles. On the last LOW cycle, register `jtag_tdo_i` into tdo[i], then go to HIGH.
  - HIGH: `jtag_tck_o`=1, TMS/TDI unchanged. Hold for ClkDiv cycles, then:
    - if i=L-1, go to RESP;
    - otherwise i++ and go to LOW. The new TMS/TDI and the TCK fall take effect on the same edge.
  - RESP: `rsp_valid_o`=1 and `rsp_tdo_o` stable. When `rsp_ready_i`=1, go to IDLE.
- After the last HIGH phase: TCK=0 and TMS/TDI keep their last values until the next command.
- Reset values: `jtag_tck_o`=0, `jtag_tms_o`=1, `jtag_tdi_o`=0, `rsp_valid_o`=0, `rsp_tdo_o`=0, `busy_o`=0, `cmd_ready_o`=1 (see Configuration). TMS idles high so a stream of TCK pulses steers the TAP toward Test-Logic-Reset.
- Reset mid-command: the current shift is abandoned with no response. All outputs take their reset values on the next edge. No partial TCK pulse is extended.

## Timing
- Command accepted at edge 0; first LOW cycle is cycle 1.
- Each bit takes 2·ClkDiv cycles.
- `rsp_valid_o` first asserts at cycle 1+2·ClkDiv·L. For L=0 it asserts at cycle 1.
- TDO is sampled one `clk_i` before the TCK rising edge. This gives a full ClkDiv-cycle setup after the target's falling-edge update.
- `cmd_ready_o` is low from acceptance until the response handshake completes. The next accept is possible at the earliest one cycle after the response handshake.
- `rsp_tdo_o` and `rsp_valid_o` are registered and must not change while `rsp_valid_o`=1 and `rsp_ready_i`=0.

## Configuration
- `JTAG_HOST_TRST_EN` defined:
  - The `jtag_trst_no` port exists.
  - It is 0 while `rst_i`=1 and for 2·ClkDiv cycles after reset release.
  - `cmd_ready_o` stays 0 during that window. Otherwise `jtag_trst_no`=1.
- `JTAG_HOST_TRST_EN` not defined: the port is absent, and `cmd_ready_o`=1 on the first cycle after reset release.

## Structure
- Shared package `jtag_host_pkg`:
  - `MaxLen` default constant;
  - `jtag_cmd_t` struct (len, tms, tdi);
  - `jtag_rsp_t` struct (tdo);
  - FSM state enum `jtag_host_state_e` (IDLE, LOW, HIGH, RESP).
- One sub-module, `jtag_host_div`: phase counter counting 0..ClkDiv-1. It produces `phase_last_o` and restarts on an enable rising edge. The top holds the FSM, the bit index and the shift registers.

## Test plan
- Basic sequence: ClkDiv=2, len=5, tms=5'b11111, tdi=0 → exactly 5 TCK pulses, each high for 2 cycles and low for 2 cycles; TMS=1 throughout; `rsp_valid_o` at cycle 21.
- Loopback: `jtag_tdo_i` tied to `jtag_tdi_o`, len=32, tdi=32'hA5A5_5A5A → `rsp_tdo_o`=32'hA5A5_5A5A.
- Backpressure: `rsp_ready_i` held 0 for 10 cycles → `rsp_tdo_o` stable, `cmd_ready_o`=0, a second `cmd_valid_i` is not accepted and no TCK edges occur; release → handshake, then `cmd_ready_o`=1.
- Length corner cases:
  - len=0 → `rsp_valid_o` at cycle 1, `rsp_tdo_o`=0, no TCK edge;
  - len=40 → exactly 32 TCK pulses.
- Reset mid-shift: `rst_i` asserted after the 3rd TCK rise → next cycle TCK=0, TMS=1, TDI=0, `rsp_valid_o`=0, `busy_o`=0; no response is ever produced for that command.
- With `JTAG_HOST_TRST_EN`, ClkDiv=4 → `jtag_trst_no`=0 and `cmd_ready_o`=0 for 8 cycles after reset release, then both are 1.

Source files
------------

// File: rtl/jtag_host_pkg.sv
// Shared types and defaults for the JTAG host.
package jtag_host_pkg;

  localparam int unsigned MaxLenDefault = 32;
  localparam int unsigned LenWDefault   = $clog2(MaxLenDefault) + 1;

  typedef struct packed {
    logic [LenWDefault-1:0]   len;
    logic [MaxLenDefault-1:0] tms;
    logic [MaxLenDefault-1:0] tdi;
  } jtag_cmd_t;

  typedef struct packed {
    logic [MaxLenDefault-1:0] tdo;
  } jtag_rsp_t;

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    RESP
  } jtag_host_state_e;

endpackage

// File: rtl/jtag_host_div.sv
// TCK phase counter: counts 0..ClkDiv-1 while enabled, restarting on an
// enable rising edge, and flags the last cycle of each phase.
module jtag_host_div #(
  parameter int unsigned ClkDiv = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic phase_last_o
);

  localparam int unsigned CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
  localparam logic [CntW-1:0] Last = CntW'(ClkDiv - 1);

  logic [CntW-1:0] cnt_q, cnt_d, cnt_cur;
  logic            en_q;

  // Current count (forced to 0 on enable rise) and wrap-around next count.
  always_comb begin
    cnt_cur      = (en_i && !en_q) ? '0 : cnt_q;
    phase_last_o = en_i && (cnt_cur == Last);
    cnt_d        = '0;
    if (en_i && (cnt_cur != Last)) begin
      cnt_d = cnt_cur + CntW'(1);
    end
  end

  // Counter and enable-edge history registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en_i;
    end
  end

endmodule

// File: rtl/jtag_host.sv
// JTAG initiator: shifts caller-supplied TMS/TDI vectors out on TCK and
// returns captured TDO. Optional TRST output enabled by JTAG_HOST_TRST_EN.
module jtag_host
  import jtag_host_pkg::*;
#(
  parameter int unsigned ClkDiv = 4,
  parameter int unsigned MaxLen = MaxLenDefault,
  localparam int unsigned LenW  = $clog2(MaxLen) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [LenW-1:0]   cmd_len_i,
  input  logic [MaxLen-1:0] cmd_tms_i,
  input  logic [MaxLen-1:0] cmd_tdi_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [MaxLen-1:0] rsp_tdo_o,
  output logic              busy_o,
  output logic              jtag_tck_o,
  output logic              jtag_tms_o,
  output logic              jtag_tdi_o,
  input  logic              jtag_tdo_i
`ifdef JTAG_HOST_TRST_EN
  ,
  output logic              jtag_trst_no
`endif
);

  localparam int unsigned IdxW = (MaxLen > 1) ? $clog2(MaxLen) : 1;

  jtag_host_state_e  state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [LenW-1:0]   len_q, len_d, eff_len;
  logic [MaxLen-1:0] tms_sr_q, tms_sr_d, tdi_sr_q, tdi_sr_d, tdo_q, tdo_d;
  logic              tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              phase_last;
  logic              trst_done;

  jtag_host_div #(
    .ClkDiv(ClkDiv)
  ) u_div (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        ((state_q == LOW) || (state_q == HIGH)),
    .phase_last_o(phase_last)
  );

`ifdef JTAG_HOST_TRST_EN
  localparam int unsigned TrstCycles = 2 * ClkDiv;
  localparam int unsigned TrstW      = $clog2(TrstCycles + 1);

  logic [TrstW-1:0] trst_cnt_q;
  logic             trst_n_q;

  // Hold TRST low for 2*ClkDiv cycles after reset release.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trst_cnt_q <= '0;
      trst_n_q   <= 1'b0;
    end else if (!trst_n_q) begin
      trst_cnt_q <= trst_cnt_q + TrstW'(1);
      if (trst_cnt_q == TrstW'(TrstCycles - 1)) begin
        trst_n_q <= 1'b1;
      end
    end
  end

  assign jtag_trst_no = trst_n_q;
  assign trst_done    = trst_n_q;
`else
  assign trst_done = 1'b1;
`endif

  assign cmd_ready_o = (state_q == IDLE) && trst_done;
  assign busy_o      = (state_q != IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_tdo_o   = tdo_q;
  assign jtag_tck_o  = tck_q;
  assign jtag_tms_o  = tms_q;
  assign jtag_tdi_o  = tdi_q;

  // FSM next state and datapath updates; pin outputs are registered so the
  // TMS/TDI change and the TCK fall land on the same edge.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    tms_sr_d    = tms_sr_q;
    tdi_sr_d    = tdi_sr_q;
    tdo_d       = tdo_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    rsp_valid_d = rsp_valid_q;
    eff_len     = (cmd_len_i > LenW'(MaxLen)) ? LenW'(MaxLen) : cmd_len_i;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          tms_sr_d = cmd_tms_i;
          tdi_sr_d = cmd_tdi_i;
          tdo_d    = '0;
          len_d    = eff_len;
          idx_d    = '0;
          if (eff_len == '0) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = LOW;
            tck_d   = 1'b0;
            tms_d   = cmd_tms_i[0];
            tdi_d   = cmd_tdi_i[0];
          end
        end
      end
      LOW: begin
        if (phase_last) begin
          tdo_d[idx_q] = jtag_tdo_i;
          tck_d        = 1'b1;
          state_d      = HIGH;
        end
      end
      HIGH: begin
        if (phase_last) begin
          tck_d = 1'b0;
          if ((LenW'(idx_q) + LenW'(1)) == len_q) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            tms_d   = tms_sr_q[idx_d];
            tdi_d   = tdi_sr_q[idx_d];
            state_d = LOW;
          end
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, shift registers and pin registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      tms_sr_q    <= '0;
      tdi_sr_q    <= '0;
      tdo_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      tms_sr_q    <= tms_sr_d;
      tdi_sr_q    <= tdi_sr_d;
      tdo_q       <= tdo_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_jtag_host.sv
// Self-checking bench for jtag_host (ClkDiv=2, MaxLen=32). Also covers the
// TRST window when built with JTAG_HOST_TRST_EN.
module tb_jtag_host;
  import jtag_host_pkg::*;

  localparam int unsigned CD = 2;
  localparam int unsigned ML = 32;
  localparam int unsigned LW = $clog2(ML) + 1;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic [LW-1:0] cmd_len_i = '0;
  logic [ML-1:0] cmd_tms_i = '0;
  logic [ML-1:0] cmd_tdi_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [ML-1:0] rsp_tdo_o;
  logic          busy_o;
  logic          jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_tdo_i;
  logic          loopback = 1'b0;
  logic          tdo_model = 1'b0;
`ifdef JTAG_HOST_TRST_EN
  logic          jtag_trst_no;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  // Target model: either a wire back from TDI or a bench-driven bit stream.
  assign jtag_tdo_i = loopback ? jtag_tdi_o : tdo_model;

  jtag_host #(
    .ClkDiv(CD),
    .MaxLen(ML)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_len_i   (cmd_len_i),
    .cmd_tms_i   (cmd_tms_i),
    .cmd_tdi_i   (cmd_tdi_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_tdo_o   (rsp_tdo_o),
    .busy_o      (busy_o),
    .jtag_tck_o  (jtag_tck_o),
    .jtag_tms_o  (jtag_tms_o),
    .jtag_tdi_o  (jtag_tdi_o),
    .jtag_tdo_i  (jtag_tdo_i)
`ifdef JTAG_HOST_TRST_EN
    ,
    .jtag_trst_no(jtag_trst_no)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with reset asserted; releases it and checks the
  // reset values and the post-reset ready/TRST window.
  task automatic release_reset();
    rst_i = 1'b0;
    check("rst_tck", 64'(jtag_tck_o), 64'd0);
    check("rst_tms", 64'(jtag_tms_o), 64'd1);
    check("rst_tdi", 64'(jtag_tdi_o), 64'd0);
    check("rst_rspv", 64'(rsp_valid_o), 64'd0);
    check("rst_tdo", 64'(rsp_tdo_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
`ifdef JTAG_HOST_TRST_EN
    for (int i = 0; i < 2 * CD; i++) begin
      check("trst_lo", 64'(jtag_trst_no), 64'd0);
      check("rdy_lo", 64'(cmd_ready_o), 64'd0);
      @(negedge clk);
    end
    check("trst_hi", 64'(jtag_trst_no), 64'd1);
`endif
    check("rst_rdy", 64'(cmd_ready_o), 64'd1);
  endtask

  // Issue one command, observe the pins, then hold off the response.
  task automatic run_cmd(input jtag_cmd_t c, input bit loop, input int hold);
    int          L;
    int          t;
    int          run;
    int          rises;
    int          w;
    logic        prev;
    logic [31:0] pat;
    logic [31:0] msk;
    logic [31:0] expv;
    L    = (int'(c.len) > ML) ? ML : int'(c.len);
    pat  = $urandom;
    msk  = (L >= 32) ? 32'hFFFF_FFFF : ((32'd1 << L) - 32'd1);
    expv = (loop ? c.tdi : pat) & msk;
    w = 0;
    while (!cmd_ready_o && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("ready", 64'(cmd_ready_o), 64'd1);
    loopback    = loop;
    tdo_model   = pat[0];
    cmd_valid_i = 1'b1;
    cmd_len_i   = c.len;
    cmd_tms_i   = c.tms;
    cmd_tdi_i   = c.tdi;
    rsp_ready_i = 1'b0;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    t     = 1;
    run   = 0;
    rises = 0;
    prev  = 1'b0;
    check("rdy_busy", 64'(cmd_ready_o), 64'd0);
    check("busy", 64'(busy_o), 64'd1);
    while (!rsp_valid_o && t <= 1 + 2 * CD * ML + 10) begin
      if (jtag_tck_o !== prev) begin
        check("phase_len", 64'(run), 64'(CD));
        if (jtag_tck_o) begin
          check("tms_bit", 64'(jtag_tms_o), 64'(c.tms[rises]));
          check("tdi_bit", 64'(jtag_tdi_o), 64'(c.tdi[rises]));
          rises++;
        end else if (rises < 32) begin
          tdo_model = pat[rises];
        end
        run = 0;
      end
      run++;
      prev = jtag_tck_o;
      @(negedge clk);
      t++;
    end
    check("latency", 64'(t), 64'(1 + 2 * CD * L));
    check("pulses", 64'(rises), 64'(L));
    if (L > 0) check("last_high", 64'(run), 64'(CD));
    check("tck_end", 64'(jtag_tck_o), 64'd0);
    check("tdo", 64'(rsp_tdo_o), 64'(expv));
    for (int h = 0; h < hold; h++) begin
      cmd_valid_i = 1'b1;
      cmd_len_i   = LW'($urandom_range(1, 8));
      @(negedge clk);
      check("hold_v", 64'(rsp_valid_o), 64'd1);
      check("hold_tdo", 64'(rsp_tdo_o), 64'(expv));
      check("hold_rdy", 64'(cmd_ready_o), 64'd0);
      check("hold_tck", 64'(jtag_tck_o), 64'd0);
    end
    cmd_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    check("hs_v", 64'(rsp_valid_o), 64'd0);
    check("hs_rdy", 64'(cmd_ready_o), 64'd1);
    check("hs_busy", 64'(busy_o), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    jtag_cmd_t c;
    int        rises;
    int        n;
    logic      prev;
    bit        seen;

    repeat (3) @(negedge clk);
    release_reset();

    // Five TMS-high pulses.
    c.len = LW'(5); c.tms = 32'h1F; c.tdi = '0;
    run_cmd(c, 1'b0, 0);
    // 32-bit loopback.
    c.len = LW'(32); c.tms = '0; c.tdi = 32'hA5A5_5A5A;
    run_cmd(c, 1'b1, 0);
    // Backpressure with a competing command.
    c.len = LW'(7); c.tms = $urandom; c.tdi = $urandom;
    run_cmd(c, 1'b0, 10);
    // Zero and oversize lengths.
    c.len = LW'(0); c.tms = $urandom; c.tdi = $urandom;
    run_cmd(c, 1'b0, 1);
    c.len = LW'(40); c.tms = $urandom; c.tdi = $urandom;
    run_cmd(c, 1'b0, 0);
    c.len = LW'(1); c.tms = $urandom; c.tdi = $urandom;
    run_cmd(c, 1'b1, 0);

    for (int k = 0; k < 14; k++) begin
      c.len = LW'($urandom_range(0, 40));
      c.tms = $urandom;
      c.tdi = $urandom;
      run_cmd(c, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    // Reset after the third TCK rise abandons the command.
    loopback    = 1'b0;
    cmd_valid_i = 1'b1;
    cmd_len_i   = LW'(10);
    cmd_tms_i   = $urandom;
    cmd_tdi_i   = 32'hFFFF_FFFF;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    rises = 0;
    prev  = 1'b0;
    n     = 0;
    while (rises < 3 && n < 200) begin
      if (jtag_tck_o && !prev) rises++;
      prev = jtag_tck_o;
      if (rises < 3) begin
        @(negedge clk);
        n++;
      end
    end
    check("rise3", 64'(rises), 64'd3);
    rst_i = 1'b1;
    @(negedge clk);
    check("mid_tck", 64'(jtag_tck_o), 64'd0);
    check("mid_tms", 64'(jtag_tms_o), 64'd1);
    check("mid_tdi", 64'(jtag_tdi_o), 64'd0);
    check("mid_rspv", 64'(rsp_valid_o), 64'd0);
    check("mid_busy", 64'(busy_o), 64'd0);
    release_reset();
    seen = 1'b0;
    repeat (4 * CD * 10 + 20) begin
      @(negedge clk);
      if (rsp_valid_o) seen = 1'b1;
    end
    check("no_resp", 64'(seen), 64'd0);

    // Still usable after the abandoned command.
    c.len = LW'(12); c.tms = $urandom; c.tdi = $urandom;
    run_cmd(c, 1'b1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
